// File: rtl/tetris_pkg.sv
// Shared constants, piece codes, board masks and FSM types for the falling-piece logic.
package tetris_pkg;

  localparam int BOARD_W  = 32;
  localparam int ROW_W    = 4;
  localparam int NUM_ROWS = 8;

  localparam logic [1:0] PIECE_SINGLE = 2'b00;
  localparam logic [1:0] PIECE_HPAIR  = 2'b01;
  localparam logic [1:0] PIECE_SQUARE = 2'b10;
  localparam logic [1:0] PIECE_L      = 2'b11;

  localparam logic [BOARD_W-1:0] COL0_MASK       = 32'h1111_1111;
  localparam logic [BOARD_W-1:0] COL3_MASK       = 32'h8888_8888;
  localparam logic [BOARD_W-1:0] BOTTOM_ROW_MASK = 32'hF000_0000;

  localparam logic [2:0] PHASE_GEN   = 3'd0;
  localparam logic [2:0] PHASE_CLEAR = 3'd1;
  localparam logic [2:0] PHASE_FALL  = 3'd2;
  localparam logic [2:0] PHASE_OVER  = 3'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FALL,
    ST_DROP,
    ST_LOCK,
    ST_OVER
  } state_e;

  typedef enum logic [1:0] {
    DIR_DOWN  = 2'd0,
    DIR_LEFT  = 2'd1,
    DIR_RIGHT = 2'd2
  } dir_e;

  // Every piece spawns in rows 0-1, columns 1-2.
  function automatic logic [BOARD_W-1:0] spawn_mask(input logic [1:0] piece);
    logic [BOARD_W-1:0] m;
    case (piece)
      PIECE_SINGLE: m = 32'h0000_0002;
      PIECE_HPAIR:  m = 32'h0000_0006;
      PIECE_SQUARE: m = 32'h0000_0066;
      default:      m = 32'h0000_0062;
    endcase
    return m;
  endfunction

  function automatic logic [2:0] phase_of(input state_e st);
    logic [2:0] p;
    case (st)
      ST_IDLE: p = PHASE_GEN;
      ST_LOCK: p = PHASE_CLEAR;
      ST_OVER: p = PHASE_OVER;
      default: p = PHASE_FALL;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/piece_shift_check.sv
// Combinational one-step shift of the active-piece mask with wall/floor and settled-cell collision test.
module piece_shift_check
  import tetris_pkg::*;
(
  input  logic [BOARD_W-1:0] mask_i,
  input  logic [BOARD_W-1:0] settled_i,
  input  dir_e               dir_i,
  output logic [BOARD_W-1:0] shifted_o,
  output logic               blocked_o
);

  logic edge_hit;

  always_comb begin
    shifted_o = mask_i;
    edge_hit  = 1'b0;
    case (dir_i)
      DIR_DOWN: begin
        shifted_o = mask_i << ROW_W;
        edge_hit  = |(mask_i & BOTTOM_ROW_MASK);
      end
      DIR_LEFT: begin
        shifted_o = mask_i >> 1;
        edge_hit  = |(mask_i & COL0_MASK);
      end
      DIR_RIGHT: begin
        shifted_o = mask_i << 1;
        edge_hit  = |(mask_i & COL3_MASK);
      end
      default: begin
        shifted_o = mask_i;
        edge_hit  = 1'b1;
      end
    endcase
    blocked_o = edge_hit | (|(shifted_o & settled_i));
  end

endmodule

// File: rtl/piece_mover.sv
// Falling-piece controller: spawn split, lateral moves, gravity, hard drop and lock.
// Optional SOFT_DROP_EN adds a soft_drop input that shortens the gravity period.
module piece_mover
  import tetris_pkg::*;
#(
  parameter int GRAVITY_DIV = 8
) (
  input  logic               clka,
  input  logic               restart_n,
  input  logic               spawn_valid,
  output logic               spawn_ready,
  input  logic [BOARD_W-1:0] board_in,
  input  logic [1:0]         curr_piece,
  input  logic               spawn_error,
  input  logic               move_left,
  input  logic               move_right,
  input  logic               hard_drop,
`ifdef SOFT_DROP_EN
  input  logic               soft_drop,
`endif
  output logic [BOARD_W-1:0] board_out,
  output logic               locked,
  output logic               game_over,
  output logic [2:0]         phase
);

  localparam int CNT_W = $clog2(GRAVITY_DIV + 1);
  localparam logic [CNT_W-1:0] THR_NORMAL = CNT_W'(GRAVITY_DIV - 1);
`ifdef SOFT_DROP_EN
  localparam int SOFT_DIV = ((GRAVITY_DIV / 4) > 1) ? (GRAVITY_DIV / 4) : 1;
  localparam logic [CNT_W-1:0] THR_SOFT = CNT_W'(SOFT_DIV - 1);
`endif

  state_e             state_q, state_d;
  logic [BOARD_W-1:0] mask_q, mask_d;
  logic [BOARD_W-1:0] settled_q, settled_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BOARD_W-1:0] board_out_q;
  logic               locked_q, game_over_q;
  logic [2:0]         phase_q;

  logic [BOARD_W-1:0] shifted [3];
  logic [2:0]         blocked;
  logic [BOARD_W-1:0] new_mask;
  logic [CNT_W-1:0]   thr;
  logic               lat_ok;
  logic               tick;

  for (genvar gi = 0; gi < 3; gi++) begin : g_chk
    piece_shift_check u_chk (
      .mask_i    (mask_q),
      .settled_i (settled_q),
      .dir_i     (dir_e'(2'(gi))),
      .shifted_o (shifted[gi]),
      .blocked_o (blocked[gi])
    );
  end

`ifdef SOFT_DROP_EN
  assign thr = soft_drop ? THR_SOFT : THR_NORMAL;
`else
  assign thr = THR_NORMAL;
`endif

  assign new_mask    = spawn_mask(curr_piece);
  // >= so a switch to a shorter period ticks at once if the count is already past it.
  assign tick        = (cnt_q >= thr);
  assign spawn_ready = (state_q == ST_IDLE);

  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    settled_d = settled_q;
    cnt_d     = cnt_q;
    lat_ok    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (spawn_valid) begin
          mask_d    = new_mask;
          settled_d = board_in & ~new_mask;
          cnt_d     = '0;
          state_d   = spawn_error ? ST_OVER : ST_FALL;
        end
      end
      ST_FALL: begin
        if (hard_drop) begin
          state_d = ST_DROP;
        end else begin
          if (move_left && !move_right && !blocked[DIR_LEFT]) begin
            mask_d = shifted[DIR_LEFT];
            lat_ok = 1'b1;
          end else if (move_right && !move_left && !blocked[DIR_RIGHT]) begin
            mask_d = shifted[DIR_RIGHT];
            lat_ok = 1'b1;
          end
          // An accepted lateral move defers the tick; the counter parks at its terminal value.
          if (tick) begin
            if (!lat_ok) begin
              cnt_d = '0;
              if (!blocked[DIR_DOWN]) mask_d = shifted[DIR_DOWN];
              else                    state_d = ST_LOCK;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_DROP: begin
        if (!blocked[DIR_DOWN]) mask_d = shifted[DIR_DOWN];
        else                    state_d = ST_LOCK;
      end
      ST_LOCK: begin
        settled_d = settled_q | mask_q;
        mask_d    = '0;
        state_d   = ST_IDLE;
      end
      ST_OVER: begin
        state_d = ST_OVER;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clka or negedge restart_n) begin
    if (!restart_n) begin
      state_q     <= ST_IDLE;
      mask_q      <= '0;
      settled_q   <= '0;
      cnt_q       <= '0;
      board_out_q <= '0;
      locked_q    <= 1'b0;
      game_over_q <= 1'b0;
      phase_q     <= PHASE_GEN;
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      settled_q   <= settled_d;
      cnt_q       <= cnt_d;
      board_out_q <= settled_d | mask_d;
      locked_q    <= (state_d == ST_LOCK);
      game_over_q <= (state_d == ST_OVER);
      phase_q     <= phase_of(state_d);
    end
  end

  assign board_out = board_out_q;
  assign locked    = locked_q;
  assign game_over = game_over_q;
  assign phase     = phase_q;

endmodule

// File: tb/tb_piece_mover.sv
// Self-checking bench for piece_mover: directed scenarios plus randomized play against a cell-level model.
module tb_piece_mover;

  localparam int GDIV = 4;

  logic        clka = 1'b0;
  logic        restart_n = 1'b0;
  logic        spawn_valid = 1'b0;
  logic        spawn_ready;
  logic [31:0] board_in = '0;
  logic [1:0]  curr_piece = '0;
  logic        spawn_error = 1'b0;
  logic        move_left = 1'b0;
  logic        move_right = 1'b0;
  logic        hard_drop = 1'b0;
`ifdef SOFT_DROP_EN
  logic        soft_drop = 1'b0;
`endif
  logic [31:0] board_out;
  logic        locked;
  logic        game_over;
  logic [2:0]  phase;

  int total = 0;
  int bad = 0;

  always #5 clka = ~clka;

  piece_mover #(.GRAVITY_DIV(GDIV)) dut (
    .clka        (clka),
    .restart_n   (restart_n),
    .spawn_valid (spawn_valid),
    .spawn_ready (spawn_ready),
    .board_in    (board_in),
    .curr_piece  (curr_piece),
    .spawn_error (spawn_error),
    .move_left   (move_left),
    .move_right  (move_right),
    .hard_drop   (hard_drop),
`ifdef SOFT_DROP_EN
    .soft_drop   (soft_drop),
`endif
    .board_out   (board_out),
    .locked      (locked),
    .game_over   (game_over),
    .phase       (phase)
  );

  // ---------------- reference model: grid of settled cells plus a list of piece cells ----------------
  int shape_n [4] = '{1, 2, 4, 3};
  int shape_r [4][4] = '{'{0,0,0,0}, '{0,0,0,0}, '{0,0,1,1}, '{0,1,1,0}};
  int shape_c [4][4] = '{'{1,0,0,0}, '{1,2,0,0}, '{1,2,1,2}, '{1,1,2,0}};

  int m_mode;            // 0 idle, 1 falling, 2 dropping, 3 locking, 4 game over
  bit m_set [8][4];
  int m_n;
  int m_r [4];
  int m_c [4];
  int m_cnt;

  function automatic logic [31:0] shape_bits(input logic [1:0] p);
    logic [31:0] b = '0;
    for (int i = 0; i < shape_n[p]; i++)
      b = b | (32'h1 << (shape_r[p][i] * 4 + shape_c[p][i]));
    return b;
  endfunction

  function automatic void model_reset();
    m_mode = 0;
    m_n = 0;
    m_cnt = 0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 4; c++)
        m_set[r][c] = 1'b0;
  endfunction

  function automatic bit m_free(input int dr, input int dc);
    for (int i = 0; i < m_n; i++) begin
      int nr = m_r[i] + dr;
      int nc = m_c[i] + dc;
      if (nr < 0 || nr > 7 || nc < 0 || nc > 3) return 1'b0;
      if (m_set[nr][nc]) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic void m_shift(input int dr, input int dc);
    for (int i = 0; i < m_n; i++) begin
      m_r[i] = m_r[i] + dr;
      m_c[i] = m_c[i] + dc;
    end
  endfunction

  function automatic logic [31:0] m_board();
    logic [31:0] b = '0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 4; c++)
        if (m_set[r][c]) b = b | (32'h1 << (r * 4 + c));
    for (int i = 0; i < m_n; i++)
      b = b | (32'h1 << (m_r[i] * 4 + m_c[i]));
    return b;
  endfunction

  function automatic logic [37:0] m_outs();
    logic [2:0] ph;
    case (m_mode)
      0: ph = 3'd0;
      1, 2: ph = 3'd2;
      3: ph = 3'd1;
      default: ph = 3'd3;
    endcase
    return {m_board(), (m_mode == 3), ph, (m_mode == 4), (m_mode == 0)};
  endfunction

  function automatic void model_step();
    bit acted;
    case (m_mode)
      0: if (spawn_valid) begin
        int p = int'(curr_piece);
        for (int r = 0; r < 8; r++)
          for (int c = 0; c < 4; c++)
            m_set[r][c] = board_in[r * 4 + c];
        m_n = shape_n[p];
        for (int i = 0; i < m_n; i++) begin
          m_r[i] = shape_r[p][i];
          m_c[i] = shape_c[p][i];
          m_set[m_r[i]][m_c[i]] = 1'b0;
        end
        m_cnt = 0;
        m_mode = spawn_error ? 4 : 1;
      end
      1: if (hard_drop) begin
        m_mode = 2;
      end else begin
        acted = 1'b0;
        if (move_left && !move_right && m_free(0, -1)) begin
          m_shift(0, -1);
          acted = 1'b1;
        end else if (move_right && !move_left && m_free(0, 1)) begin
          m_shift(0, 1);
          acted = 1'b1;
        end
        if (m_cnt == GDIV - 1) begin
          if (!acted) begin
            m_cnt = 0;
            if (m_free(1, 0)) m_shift(1, 0);
            else m_mode = 3;
          end
        end else begin
          m_cnt++;
        end
      end
      2: if (m_free(1, 0)) m_shift(1, 0); else m_mode = 3;
      3: begin
        for (int i = 0; i < m_n; i++) m_set[m_r[i]][m_c[i]] = 1'b1;
        m_n = 0;
        m_mode = 0;
      end
      default: ;
    endcase
  endfunction

  // ---------------- stimulus plumbing ----------------
  task automatic cyc();
    @(posedge clka);
    model_step();
    @(negedge clka);
  endtask

  task automatic clear_inputs();
    spawn_valid = 1'b0;
    spawn_error = 1'b0;
    move_left   = 1'b0;
    move_right  = 1'b0;
    hard_drop   = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clka);
    restart_n = 1'b0;
    clear_inputs();
    model_reset();
    @(negedge clka);
    @(negedge clka);
    restart_n = 1'b1;
  endtask

  task automatic spawn(input logic [1:0] p, input logic [31:0] b);
    spawn_valid = 1'b1;
    curr_piece  = p;
    board_in    = b;
    cyc();
    spawn_valid = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    total++;
    if ({board_out, locked, phase, game_over, spawn_ready} !== {32'h0, 1'b0, 3'd0, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL reset_values got board=%h lk=%b ph=%0d go=%b rdy=%b want board=0 lk=0 ph=0 go=0 rdy=1",
               board_out, locked, phase, game_over, spawn_ready);
    end
    $display("reset: board=%h phase=%0d ready=%b", board_out, phase, spawn_ready);
  endtask

  task automatic test_square_fall();
    do_reset();
    spawn(2'b10, 32'h66);
    total++;
    if (board_out !== 32'h66 || phase !== 3'd2) begin
      bad++;
      $display("FAIL spawn_latency got board=%h ph=%0d want board=00000066 ph=2", board_out, phase);
    end
    repeat (GDIV - 1) cyc();
    total++;
    if (board_out !== 32'h66) begin
      bad++;
      $display("FAIL early_gravity got=%h want=00000066", board_out);
    end
    cyc();
    total++;
    if (board_out !== 32'h660) begin
      bad++;
      $display("FAIL gravity_step got=%h want=00000660", board_out);
    end
    $display("square_fall: board=%h", board_out);
  endtask

  task automatic test_lock_floor();
    repeat (5 * GDIV) cyc();
    total++;
    if (board_out !== 32'h6600_0000 || locked !== 1'b0) begin
      bad++;
      $display("FAIL floor_reach got board=%h lk=%b want board=66000000 lk=0", board_out, locked);
    end
    repeat (GDIV - 1) cyc();
    total++;
    if (locked !== 1'b0) begin
      bad++;
      $display("FAIL early_lock got=%b want=0", locked);
    end
    cyc();
    total++;
    if (locked !== 1'b1 || phase !== 3'd1 || board_out !== 32'h6600_0000) begin
      bad++;
      $display("FAIL floor_lock got lk=%b ph=%0d board=%h want lk=1 ph=1 board=66000000", locked, phase, board_out);
    end
    cyc();
    total++;
    if (locked !== 1'b0 || spawn_ready !== 1'b1 || phase !== 3'd0 || board_out !== 32'h6600_0000) begin
      bad++;
      $display("FAIL after_lock got lk=%b rdy=%b ph=%0d board=%h want lk=0 rdy=1 ph=0 board=66000000",
               locked, spawn_ready, phase, board_out);
    end
    $display("lock_floor: board=%h", board_out);
  endtask

  task automatic test_left_wall();
    // {move_left, move_right} per cycle and the board expected after it
    logic [1:0]  mv [10] = '{2'b00, 2'b10, 2'b10, 2'b11, 2'b01, 2'b00, 2'b01, 2'b01, 2'b01, 2'b01};
    logic [31:0] ex [10] = '{32'h2, 32'h1, 32'h1, 32'h1, 32'h2, 32'h20, 32'h40, 32'h80, 32'h80, 32'h800};
    do_reset();
    for (int i = 0; i < 10; i++) begin
      if (i == 0) begin
        spawn(2'b00, 32'h2);
      end else begin
        {move_left, move_right} = mv[i];
        cyc();
        {move_left, move_right} = 2'b00;
      end
      total++;
      if (board_out !== ex[i]) begin
        bad++;
        $display("FAIL lateral_step%0d got=%h want=%h", i, board_out, ex[i]);
      end
    end
    $display("lateral: board=%h", board_out);
  endtask

  task automatic test_collision();
    do_reset();
    spawn(2'b00, 32'h0000_0F02);
    repeat (GDIV) cyc();
    total++;
    if (board_out !== 32'h0000_0F20 || locked !== 1'b0) begin
      bad++;
      $display("FAIL collide_step got board=%h lk=%b want board=00000f20 lk=0", board_out, locked);
    end
    repeat (GDIV) cyc();
    total++;
    if (locked !== 1'b1 || board_out !== 32'h0000_0F20) begin
      bad++;
      $display("FAIL collide_lock got lk=%b board=%h want lk=1 board=00000f20", locked, board_out);
    end
    $display("collision: board=%h locked=%b", board_out, locked);
  endtask

  task automatic test_hard_drop();
    logic [31:0] exp;
    do_reset();
    spawn(2'b10, 32'h66);
    hard_drop = 1'b1;
    cyc();
    hard_drop = 1'b0;
    total++;
    if (board_out !== 32'h66 || phase !== 3'd2) begin
      bad++;
      $display("FAIL drop_accept got board=%h ph=%0d want board=00000066 ph=2", board_out, phase);
    end
    for (int k = 1; k <= 6; k++) begin
      cyc();
      exp = 32'h66 << (4 * k);
      total++;
      if (board_out !== exp || locked !== 1'b0) begin
        bad++;
        $display("FAIL drop_edge%0d got board=%h lk=%b want board=%h lk=0", k, board_out, locked, exp);
      end
    end
    cyc();
    total++;
    if (locked !== 1'b1 || phase !== 3'd1 || board_out !== 32'h6600_0000) begin
      bad++;
      $display("FAIL drop_lock got lk=%b ph=%0d board=%h want lk=1 ph=1 board=66000000", locked, phase, board_out);
    end
    $display("hard_drop: board=%h locked=%b", board_out, locked);
  endtask

  task automatic test_back_to_back();
    do_reset();
    spawn_valid = 1'b1;
    curr_piece  = 2'b10;
    board_in    = 32'h66;
    cyc();
    hard_drop = 1'b1;
    cyc();
    hard_drop = 1'b0;
    for (int i = 0; i < 20 && !locked; i++) cyc();
    total++;
    if (locked !== 1'b1) begin
      bad++;
      $display("FAIL b2b_lock_timeout got lk=%b want lk=1", locked);
    end
    board_in = 32'h6600_0066;
    cyc();
    total++;
    if (phase !== 3'd0 || spawn_ready !== 1'b1 || board_out !== 32'h6600_0000) begin
      bad++;
      $display("FAIL b2b_idle got ph=%0d rdy=%b board=%h want ph=0 rdy=1 board=66000000", phase, spawn_ready, board_out);
    end
    cyc();
    spawn_valid = 1'b0;
    total++;
    if (phase !== 3'd2 || board_out !== 32'h6600_0066) begin
      bad++;
      $display("FAIL b2b_spawn got ph=%0d board=%h want ph=2 board=66000066", phase, board_out);
    end
    $display("back_to_back: board=%h", board_out);
  endtask

  task automatic test_spawn_error_reset();
    do_reset();
    spawn_error = 1'b1;
    spawn(2'b00, 32'h2);
    spawn_error = 1'b0;
    for (int i = 0; i < 24; i++) begin
      total++;
      if ({board_out, locked, phase, game_over, spawn_ready} !== {32'h2, 1'b0, 3'd3, 1'b1, 1'b0}) begin
        bad++;
        $display("FAIL over_hold%0d got board=%h lk=%b ph=%0d go=%b rdy=%b want board=2 lk=0 ph=3 go=1 rdy=0",
                 i, board_out, locked, phase, game_over, spawn_ready);
      end
      spawn_valid = 1'($urandom_range(0, 1));
      curr_piece  = 2'($urandom_range(0, 3));
      board_in    = $urandom;
      move_left   = 1'($urandom_range(0, 1));
      move_right  = 1'($urandom_range(0, 1));
      hard_drop   = 1'($urandom_range(0, 1));
      cyc();
    end
    clear_inputs();
    $display("spawn_error: game_over=%b phase=%0d", game_over, phase);

    do_reset();
    spawn(2'b10, 32'h66);
    hard_drop = 1'b1;
    cyc();
    hard_drop = 1'b0;
    cyc();
    cyc();
    total++;
    if (board_out !== 32'h6600) begin
      bad++;
      $display("FAIL mid_drop got=%h want=00006600", board_out);
    end
    @(posedge clka);
    #2;
    restart_n = 1'b0;
    model_reset();
    #1;
    total++;
    if ({board_out, locked, phase, game_over, spawn_ready} !== {32'h0, 1'b0, 3'd0, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL async_reset got board=%h lk=%b ph=%0d go=%b rdy=%b want board=0 lk=0 ph=0 go=0 rdy=1",
               board_out, locked, phase, game_over, spawn_ready);
    end
    @(negedge clka);
    restart_n = 1'b1;
    $display("async_reset: board=%h phase=%0d", board_out, phase);
  endtask

  task automatic test_random();
    logic [37:0] want;
    logic [37:0] got;
    int locks = 0;
    do_reset();
    for (int i = 0; i < 1200; i++) begin
      spawn_valid = ($urandom_range(0, 3) == 0);
      curr_piece  = 2'($urandom_range(0, 3));
      board_in    = ($urandom & 32'hFFFF_F000) | shape_bits(curr_piece);
      spawn_error = 1'b0;
      move_left   = ($urandom_range(0, 2) == 0);
      move_right  = ($urandom_range(0, 2) == 0);
      hard_drop   = ($urandom_range(0, 24) == 0);
      cyc();
      want = m_outs();
      got  = {board_out, locked, phase, game_over, spawn_ready};
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL random_cycle%0d got=%h want=%h (board,lk,ph,go,rdy)", i, got, want);
      end
      if (locked === 1'b1) begin
        locks++;
        $display("random lock %0d: board=%h", locks, board_out);
      end
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_square_fall();
    test_lock_floor();
    test_left_wall();
    test_collision();
    test_hard_drop();
    test_back_to_back();
    test_spawn_error_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
